// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, issue FSM states and flag-register bit positions
package alu_pkg;

    localparam logic [5:0] OP_FRCPY  = 6'b000110;
    localparam logic [5:0] OP_ADD    = 6'b100000;
    localparam logic [5:0] OP_SUB    = 6'b100001;
    localparam logic [5:0] OP_MUL    = 6'b100010;
    localparam logic [5:0] OP_DIV    = 6'b100011;
    localparam logic [5:0] OP_MOD    = 6'b100101;
    localparam logic [5:0] OP_INCDEC = 6'b100100;
    localparam logic [5:0] OP_CMP    = 6'b010110;
    localparam logic [5:0] OP_AND    = 6'b010010;
    localparam logic [5:0] OP_OR     = 6'b010011;
    localparam logic [5:0] OP_XOR    = 6'b010100;
    localparam logic [5:0] OP_NOT    = 6'b010101;
    localparam logic [5:0] OP_SHIFT  = 6'b010000;
    localparam logic [5:0] OP_ADD32  = 6'b011101;

    // Stage-count and stage-counter width; wide enough for any sane latency parameter.
    localparam int LAT_W = 4;

    localparam int FR_NEG    = 6;
    localparam int FR_CARRY  = 11;
    localparam int FR_OVF    = 12;
    localparam int FR_CMP_EQ = 13;
    localparam int FR_CMP_LT = 14;
    localparam int FR_CMP_GT = 15;

    typedef enum logic [2:0] {
        ST_FLUSH   = 3'd0,
        ST_GAP     = 3'd1,
        ST_IDLE    = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request/response handshake bundle between execute FSM and ALU issue control
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_opcode;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              req_use_carry;
    logic [2:0]        req_shift_flag;
    logic              req_dec;
    logic [15:0]       req_fr;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [15:0]       rsp_fr;
    logic              rsp_err;

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_use_carry, req_shift_flag, req_dec, req_fr,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_fr, rsp_err
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_use_carry, req_shift_flag, req_dec, req_fr,
        input  rsp_ready,
        output req_ready,
        output rsp_valid, rsp_result, rsp_fr, rsp_err
    );
endinterface

// File: rtl/alu_lat_lut.sv
// rtl/alu_lat_lut.sv - combinational opcode to {known, ALU stage count} lookup
module alu_lat_lut
    import alu_pkg::*;
#(
    parameter int LAT_SHORT = 1,
    parameter int LAT_MED   = 2,
    parameter int LAT_LONG  = 3
) (
    input  logic [5:0]       opcode,
    output logic             known,
    output logic [LAT_W-1:0] lat
);

    always_comb begin
        known = 1'b1;
        lat   = '0;
        case (opcode)
            OP_FRCPY, OP_INCDEC, OP_CMP, OP_SHIFT:
                lat = LAT_W'(LAT_SHORT);
            OP_ADD, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD32:
                lat = LAT_W'(LAT_MED);
            OP_SUB:
                lat = LAT_W'(LAT_LONG);
            default: begin
                known = 1'b0;
                lat   = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue controller: post-reset stage flush, enable sequencing, result capture.
// Optional ALU_ISSUE_PERF_EN adds perf_ops / perf_busy counters.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LAT_SHORT    = 1,
    parameter int LAT_MED      = 2,
    parameter int LAT_LONG     = 3,
    parameter int FLUSH_CYCLES = 260
) (
    input  logic              wire_clock,
    input  logic              wire_reset,
    alu_issue_ctrl_if.slave   bus,
    output logic              alu_enable,
    output logic [5:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_m3,
    output logic [DATA_W-1:0] alu_m4,
    output logic [15:0]       alu_fr_in,
    output logic              alu_use_carry,
    output logic [2:0]        alu_shift_flag,
    output logic              alu_dec,
    input  logic [DATA_W-1:0] alu_m2,
    input  logic [15:0]       alu_fr_out,
    output logic              busy
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_busy
`endif
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    state_t            state_q;
    state_t            state_d;
    logic [FLUSH_W-1:0] flush_cnt_q;
    logic [LAT_W-1:0]  iss_cnt_q;
    logic [LAT_W-1:0]  lat_q;
    logic              lut_known;
    logic [LAT_W-1:0]  lut_lat;
    logic              req_fire;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_result_q;
    logic [15:0]       rsp_fr_q;
    logic              rsp_err_q;

    alu_lat_lut #(
        .LAT_SHORT (LAT_SHORT),
        .LAT_MED   (LAT_MED),
        .LAT_LONG  (LAT_LONG)
    ) u_lat_lut (
        .opcode (bus.req_opcode),
        .known  (lut_known),
        .lat    (lut_lat)
    );

    assign req_fire = (state_q == ST_IDLE) && bus.req_valid;
    assign rsp_fire = (state_q == ST_RESP) && bus.rsp_ready;

    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            state_q <= ST_FLUSH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FLUSH:   if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) state_d = ST_GAP;
            ST_GAP:     state_d = ST_IDLE;
            ST_IDLE:    if (req_fire) state_d = lut_known ? ST_ISSUE : ST_RESP;
            ST_ISSUE:   if (iss_cnt_q == lat_q) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    if (bus.rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_FLUSH;
        endcase
    end

    // Enable is high through the flush and for L+1 issue cycles; low everywhere else.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        alu_enable    = (state_q == ST_FLUSH) || (state_q == ST_ISSUE);
        busy          = (state_q != ST_IDLE);
    end

    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            flush_cnt_q    <= '0;
            iss_cnt_q      <= '0;
            lat_q          <= '0;
            alu_opcode     <= OP_FRCPY;
            alu_m3         <= '0;
            alu_m4         <= '0;
            alu_fr_in      <= '0;
            alu_use_carry  <= 1'b0;
            alu_shift_flag <= '0;
            alu_dec        <= 1'b0;
            rsp_result_q   <= '0;
            rsp_fr_q       <= '0;
            rsp_err_q      <= 1'b0;
        end else begin
            flush_cnt_q <= (state_q == ST_FLUSH) ? flush_cnt_q + 1'b1 : '0;

            if (req_fire) begin
                alu_opcode     <= bus.req_opcode;
                alu_m3         <= bus.req_a;
                alu_m4         <= bus.req_b;
                alu_fr_in      <= bus.req_fr;
                alu_use_carry  <= bus.req_use_carry;
                alu_shift_flag <= bus.req_shift_flag;
                alu_dec        <= bus.req_dec;
                lat_q          <= lut_lat;
                iss_cnt_q      <= '0;
                // Unsupported opcodes answer straight away with the caller's flags untouched.
                if (!lut_known) begin
                    rsp_result_q <= '0;
                    rsp_fr_q     <= bus.req_fr;
                    rsp_err_q    <= 1'b1;
                end
            end

            if (state_q == ST_ISSUE) begin
                iss_cnt_q <= iss_cnt_q + 1'b1;
            end

            if (state_q == ST_CAPTURE) begin
                rsp_result_q <= alu_m2;
                rsp_fr_q     <= alu_fr_out;
                rsp_err_q    <= 1'b0;
            end
        end
    end

    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_fr     = rsp_fr_q;
    assign bus.rsp_err    = rsp_err_q;

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            perf_ops  <= '0;
            perf_busy <= '0;
        end else begin
            if (rsp_fire) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if ((state_q == ST_ISSUE) || (state_q == ST_CAPTURE) || (state_q == ST_RESP)) begin
                perf_busy <= perf_busy + 32'd1;
            end
        end
    end
`else
    logic unused_rsp_fire;
    assign unused_rsp_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with a behavioural ALU stub
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        wire_clock = 1'b0;
    logic        wire_reset = 1'b1;
    always #5 wire_clock = ~wire_clock;

    alu_issue_ctrl_if #(.DATA_W(32)) bus();

    logic        alu_enable;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_m3;
    logic [31:0] alu_m4;
    logic [15:0] alu_fr_in;
    logic        alu_use_carry;
    logic [2:0]  alu_shift_flag;
    logic        alu_dec;
    logic [31:0] alu_m2     = 32'd0;
    logic [15:0] alu_fr_out = 16'd0;
    logic        busy;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_busy;
`endif

    alu_issue_ctrl #(.DATA_W(32)) dut (
        .wire_clock     (wire_clock),
        .wire_reset     (wire_reset),
        .bus            (bus),
        .alu_enable     (alu_enable),
        .alu_opcode     (alu_opcode),
        .alu_m3         (alu_m3),
        .alu_m4         (alu_m4),
        .alu_fr_in      (alu_fr_in),
        .alu_use_carry  (alu_use_carry),
        .alu_shift_flag (alu_shift_flag),
        .alu_dec        (alu_dec),
        .alu_m2         (alu_m2),
        .alu_fr_out     (alu_fr_out),
        .busy           (busy)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops       (perf_ops),
        .perf_busy      (perf_busy)
`endif
    );

    // Stand-in ALU: updates its outputs on every enabled cycle.
    function automatic logic [47:0] alu_model(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [15:0] fr,
                                              input logic dec);
        logic [32:0] sum;
        logic [31:0] r;
        logic [15:0] f;
        r = 32'd0;
        f = fr;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r = sum[31:0];
                f[FR_CARRY] = sum[32];
                f[FR_OVF]   = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                r = (a < b) ? 32'd0 : a - b;
                f[FR_NEG] = (a < b);
            end
            OP_INCDEC: r = dec ? a - 32'd1 : a + 32'd1;
            OP_MUL:    r = a * b;
            OP_CMP: begin
                f[FR_CMP_EQ] = (a == b);
                f[FR_CMP_LT] = (a < b);
                f[FR_CMP_GT] = (a > b);
            end
            default: r = 32'd0;
        endcase
        return {f, r};
    endfunction

    always @(posedge wire_clock) begin
        if (alu_enable) begin
            {alu_fr_out, alu_m2} <= alu_model(alu_opcode, alu_m3, alu_m4, alu_fr_in, alu_dec);
        end
    end

    int en_run = 0, last_pulse = 0, pulses = 0, low_run = 0, last_gap = 0;
    always @(posedge wire_clock) begin
        if (alu_enable) begin
            en_run  <= en_run + 1;
            low_run <= 0;
            if (en_run == 0) last_gap <= low_run;
        end else begin
            low_run <= low_run + 1;
            en_run  <= 0;
            if (en_run != 0) begin
                last_pulse <= en_run;
                pulses     <= pulses + 1;
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wire_clock);
        #1;
    endtask

    task automatic wait_flush(output int hi, output int lo, output int cyc, output int saw_rsp);
        hi = 0; lo = 0; cyc = 1; saw_rsp = 0;
        while (cyc < 400) begin
            if (bus.req_ready) break;
            if (alu_enable) hi++; else lo++;
            if (bus.rsp_valid) saw_rsp = 1;
            step();
            cyc++;
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 50) begin
            step();
            lat++;
        end
    endtask

    task automatic drive_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic dec, input logic [15:0] fr);
        bus.req_opcode     = op;
        bus.req_a          = a;
        bus.req_b          = b;
        bus.req_use_carry  = 1'b0;
        bus.req_shift_flag = 3'd0;
        bus.req_dec        = dec;
        bus.req_fr         = fr;
        bus.req_valid      = 1'b1;
    endtask

    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dec, input logic [15:0] fr, output int lat);
        int n;
        drive_req(op, a, b, dec, fr);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            step();
            n++;
        end
        step();
        bus.req_valid = 1'b0;
        wait_rsp(lat);
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int hi, lo, cyc, saw, lat, p0, stable;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        drive_req(6'd0, 32'd0, 32'd0, 1'b0, 16'd0);
        bus.req_valid = 1'b0;

        wire_reset = 1'b1;
        repeat (3) step();
        chk("rst_enable", alu_enable, 1);
        chk("rst_opcode", alu_opcode, OP_FRCPY);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_m3", alu_m3, 0);
        wire_reset = 1'b0;

        wait_flush(hi, lo, cyc, saw);
        chk("flush_enable_cycles", hi, 260);
        chk("flush_gap_cycles", lo, 1);
        chk("flush_ready_cycle", cyc, 262);

        run_op(OP_ADD, 32'd5, 32'd7, 1'b0, 16'h0000, lat);
        chk("add_latency", lat, 5);
        chk("add_pulse", last_pulse, 3);
        chk("add_result", bus.rsp_result, 12);
        chk("add_fr11", bus.rsp_fr[11], 0);
        chk("add_fr12", bus.rsp_fr[12], 0);
        chk("add_err", bus.rsp_err, 0);
        chk("add_m3_held", alu_m3, 5);
        chk("add_no_ready_in_resp", bus.req_ready, 0);
        ack();
        chk("add_rsp_dropped", bus.rsp_valid, 0);
        chk("add_back_to_idle", bus.req_ready, 1);

        run_op(OP_SUB, 32'd3, 32'd5, 1'b0, 16'h0000, lat);
        chk("sub_latency", lat, 6);
        chk("sub_pulse", last_pulse, 4);
        chk("sub_result", bus.rsp_result, 0);
        chk("sub_fr6", bus.rsp_fr[6], 1);
        ack();

        p0 = pulses;
        run_op(6'b111111, 32'd1, 32'd2, 1'b0, 16'hA5A5, lat);
        chk("bad_latency", lat, 1);
        chk("bad_err", bus.rsp_err, 1);
        chk("bad_result", bus.rsp_result, 0);
        chk("bad_fr", bus.rsp_fr, 16'hA5A5);
        chk("bad_no_enable", pulses, p0);
        ack();

        run_op(OP_INCDEC, 32'd9, 32'd0, 1'b0, 16'h0000, lat);
        chk("inc_latency", lat, 4);
        chk("inc_pulse", last_pulse, 2);
        drive_req(OP_INCDEC, 32'd9, 32'd0, 1'b0, 16'h0000);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            if (bus.rsp_result !== 32'd10 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1) stable = 0;
            step();
        end
        chk("inc_hold_stable", stable, 1);
        ack();
        run_op(OP_INCDEC, 32'd9, 32'd0, 1'b0, 16'h0000, lat);
        chk("inc2_latency", lat, 4);
        chk("inc2_result", bus.rsp_result, 10);

        drive_req(OP_ADD, 32'd1, 32'd2, 1'b0, 16'h0000);
        bus.rsp_ready = 1'b1;
        step();
        step();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        wait_rsp(lat);
        chk("b2b_gap_ge2", (last_gap >= 2) ? 1 : 0, 1);
        chk("b2b_result", bus.rsp_result, 3);
        ack();

        drive_req(OP_MUL, 32'd6, 32'd7, 1'b0, 16'h0000);
        step();
        bus.req_valid = 1'b0;
        step();
        chk("mul_issuing", alu_enable, 1);
        wire_reset = 1'b1;
        step();
        wire_reset = 1'b0;
        wait_flush(hi, lo, cyc, saw);
        chk("rst2_no_response", saw, 0);
        chk("rst2_flush_cycles", hi, 260);
        chk("rst2_ready_cycle", cyc, 262);

        run_op(OP_CMP, 32'd4, 32'd4, 1'b0, 16'h0000, lat);
        chk("cmp_latency", lat, 4);
        chk("cmp_fr15_13", bus.rsp_fr[15:13], 3'b001);
        ack();
`ifdef ALU_ISSUE_PERF_EN
        chk("perf_ops", perf_ops, 1);
        chk("perf_busy", perf_busy, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
